edge_level_gen: RTL and testbench
=================================

Name: edge_level_gen

Overview:
- Rebuilds a level waveform from one-cycle edge requests. This is the inverse of the edge detector: rise/fall pulses in, registered level out.
- Enforces a programmable minimum high time and minimum low time on the output. One request that arrives during a hold is buffered.
- Sits in front of any level-sensitive consumer. It can be looped back into the edge detector for self-check.

Parameters:
- MIN_HIGH, 4, minimum cycles q stays high once raised (legal range 1..2**CNT_W-1).
- MIN_LOW, 4, minimum cycles q stays low once lowered (same range).
- CNT_W, 8, width of the hold counter.
- RST_LEVEL, 0, value of q during and after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronous to clk.
- rise_req  in  1  one-cycle request to drive q high.
- fall_req  in  1  one-cycle request to drive q low.
- q  out  1  registered output level.
- q_rise  out  1  one-cycle pulse in the first cycle q is 1 after being 0.
- q_fall  out  1  one-cycle pulse in the first cycle q is 0 after being 1.
- busy  out  1  high while a minimum-time hold is in progress.
- pend  out  1  high while a buffered request waits for its hold to expire.
- coll_err  out  1  one-cycle pulse: rise_req and fall_req were sampled together.
- redund_err  out  1  one-cycle pulse: a request matched the current settled level and was dropped.

Behaviour:
- Reset values: q=RST_LEVEL, state=LOW or HIGH to match RST_LEVEL (hold already satisfied), cnt=0, pend=0, and q_rise, q_fall, busy, coll_err, redund_err all 0.
- States: LOW, LOW_HOLD, HIGH, HIGH_HOLD. Every output is registered.
- LOW + rise_req:
  - Next cycle q=1 and q_rise=1.
  - Go to HIGH_HOLD with cnt=1, or straight to HIGH if MIN_HIGH=1.
  - Latency is 1 cycle from request to q.
- HIGH_HOLD: cnt increments each cycle; at cnt==MIN_HIGH go to HIGH. q therefore stays high for at least MIN_HIGH cycles. busy=1 throughout HIGH_HOLD.
- HIGH + fall_req: mirror of the LOW case, using MIN_LOW, LOW_HOLD and q_fall.
- Opposite request during a hold (e.g. fall_req in HIGH_HOLD):
  - Sets pend.
  - On the cycle cnt reaches MIN_HIGH, skip HIGH and apply the fall directly. q is then high for exactly MIN_HIGH cycles.
  - pend clears in the same cycle q changes.
- Same-direction request during a hold with pend=1 (e.g. rise_req in HIGH_HOLD while a fall is pending): cancels the pending request and clears pend. No error.
- Same-direction request with pend=0, in a hold or settled state: dropped, redund_err pulses.
- rise_req and fall_req in the same cycle: both ignored, coll_err pulses, state and pend unchanged.
- Only one request is ever buffered. A second opposite request while pend=1 cannot occur, because it would be same-direction as the current level and cancels as above.
- Counter saturates at MIN_x and never wraps. MIN_x=0 is illegal; an elaboration check fails the build.
- Reset mid-hold: q returns to RST_LEVEL immediately (asynchronous) and any pending request is discarded.

Optional Feature:
- Macro: EDGE_LEVEL_GEN_TOGGLE_EN.
- Defined:
  - Adds input tgl_req (1 bit), which is treated as rise_req when the effective level is 0 and fall_req when it is 1.
  - Effective level means q with any pending request applied.
  - tgl_req together with rise_req or fall_req raises coll_err.
- Undefined: the port is absent and behaviour is as above.

Decomposition:
- Package edge_pkg: state enum (LOW, LOW_HOLD, HIGH, HIGH_HOLD) and a default CNT_W constant.
- Optional sub-module hold_counter: load, increment, saturate, and a done flag. Instantiated once.
- State machine and request arbitration stay in the top module.

Test Plan:
- Reset with RST_LEVEL=0, then rise_req at cycle 2 -> q=1 and q_rise=1 at cycle 3; busy=1 for cycles 3..5; q stays 1.
- Defaults; rise_req, then fall_req 1 cycle after q rises -> pend=1; q high exactly 4 cycles, then q_fall; pend clears in the same cycle q falls.
- q settled high; rise_req -> redund_err pulse, q unchanged. Then rise_req+fall_req together -> coll_err pulse, no state change.
- HIGH_HOLD with fall pending, then rise_req -> pend=0, q stays high with no falling edge.
- Reset asserted mid-LOW_HOLD with pend=1 -> q=RST_LEVEL asynchronously; after release, pend=0 and busy=0.
- With EDGE_LEVEL_GEN_TOGGLE_EN and MIN_HIGH=MIN_LOW=1: 32 random tgl_req, looped into the edge detector -> each toggle produces exactly one edge pulse of the matching direction.

Source files
------------

// File: rtl/edge_level_gen_pkg.sv
// edge_pkg: shared FSM state encoding and default counter width for edge_level_gen.
package edge_pkg;
   localparam int EDGE_CNT_W = 8;
   typedef enum logic [1:0] {
      LOW       = 2'd0,
      LOW_HOLD  = 2'd1,
      HIGH      = 2'd2,
      HIGH_HOLD = 2'd3
   } state_e;
   function automatic logic is_hold(input state_e s);
      return (s == LOW_HOLD) || (s == HIGH_HOLD);
   endfunction
endpackage

// File: rtl/edge_level_gen_hold.sv
// hold_counter: saturating minimum-time counter; done_o flags the last hold cycle.
module hold_counter
   import edge_pkg::*;
#(
   parameter int CNT_W = EDGE_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] lim_i,
   output logic             done_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign cnt_d  = load_i ? CNT_W'(1) : (inc_i && cnt_q < lim_i) ? cnt_q + CNT_W'(1) : cnt_q;
   assign done_o = ({1'b0, cnt_q} + (CNT_W+1)'(1)) >= {1'b0, lim_i};
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/edge_level_gen.sv
// edge_level_gen: rebuilds a level from rise/fall requests with min high/low hold times.
// Optional toggle request input enabled by EDGE_LEVEL_GEN_TOGGLE_EN.
module edge_level_gen
   import edge_pkg::*;
#(
   parameter int MIN_HIGH  = 4,
   parameter int MIN_LOW   = 4,
   parameter int CNT_W     = EDGE_CNT_W,
   parameter bit RST_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic rise_req,
   input  logic fall_req,
`ifdef EDGE_LEVEL_GEN_TOGGLE_EN
   input  logic tgl_req,
`endif
   output logic q,
   output logic q_rise,
   output logic q_fall,
   output logic busy,
   output logic pend,
   output logic coll_err,
   output logic redund_err
);
   if (MIN_HIGH < 1 || MIN_HIGH > 2**CNT_W-1 || MIN_LOW < 1 || MIN_LOW > 2**CNT_W-1) begin : g_bad_min
      $error("edge_level_gen: MIN_HIGH/MIN_LOW out of range");
   end
   state_e state_q, state_d;
   logic   q_q, q_d, pend_q, pend_d, busy_q, busy_d;
   logic   q_rise_q, q_rise_d, q_fall_q, q_fall_d, coll_q, coll_d, redund_q, redund_d;
   logic   r, f, coll, same, opp, hold, go, done;
   logic [CNT_W-1:0] lim;
`ifdef EDGE_LEVEL_GEN_TOGGLE_EN
   logic lvl_eff;
   // A toggle targets the level q will settle at once any buffered request lands.
   assign lvl_eff = q_q ^ pend_q;
   assign coll    = (rise_req & fall_req) | (tgl_req & (rise_req | fall_req));
   assign r       = ~coll & (rise_req | (tgl_req & ~lvl_eff));
   assign f       = ~coll & (fall_req | (tgl_req & lvl_eff));
`else
   assign coll    = rise_req & fall_req;
   assign r       = rise_req & ~coll;
   assign f       = fall_req & ~coll;
`endif
   assign same = (r & q_q) | (f & ~q_q);
   assign opp  = (r & ~q_q) | (f & q_q);
   assign hold = is_hold(state_q);
   // A settled state with a buffered request applies it immediately, so q holds exactly MIN_x.
   assign go   = ~hold & (opp | pend_q) & ~same;
   assign lim  = q_q ? CNT_W'(MIN_HIGH) : CNT_W'(MIN_LOW);
   hold_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (go),
      .inc_i  (hold),
      .lim_i  (lim),
      .done_o (done)
   );
   always_comb begin
      state_d  = go ? (q_q ? (MIN_LOW == 1 ? LOW : LOW_HOLD) : (MIN_HIGH == 1 ? HIGH : HIGH_HOLD))
               : (hold && done) ? (q_q ? HIGH : LOW) : state_q;
      q_d      = q_q ^ go;
      pend_d   = ~go & (pend_q | (hold & opp)) & ~same;
      busy_d   = is_hold(state_d);
      q_rise_d = go & ~q_q;
      q_fall_d = go & q_q;
      coll_d   = coll;
      redund_d = same & ~pend_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RST_LEVEL ? HIGH : LOW;
         q_q      <= RST_LEVEL;
         pend_q   <= 1'b0;
         busy_q   <= 1'b0;
         q_rise_q <= 1'b0;
         q_fall_q <= 1'b0;
         coll_q   <= 1'b0;
         redund_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         pend_q   <= pend_d;
         busy_q   <= busy_d;
         q_rise_q <= q_rise_d;
         q_fall_q <= q_fall_d;
         coll_q   <= coll_d;
         redund_q <= redund_d;
      end
   end
   assign q          = q_q;
   assign q_rise     = q_rise_q;
   assign q_fall     = q_fall_q;
   assign busy       = busy_q;
   assign pend       = pend_q;
   assign coll_err   = coll_q;
   assign redund_err = redund_q;
endmodule

// File: tb/tb_edge_level_gen.sv
// tb_edge_level_gen: scoreboard bench; expected output vectors queued per cycle, checked by a monitor.
module tb_edge_level_gen;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rise_req = 1'b0, fall_req = 1'b0;
   logic q, q_rise, q_fall, busy, pend, coll_err, redund_err;
   logic [6:0] sb[$];
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   edge_level_gen dut (
      .clk        (clk),
      .rst        (rst),
      .rise_req   (rise_req),
      .fall_req   (fall_req),
`ifdef EDGE_LEVEL_GEN_TOGGLE_EN
      .tgl_req    (1'b0),
`endif
      .q          (q),
      .q_rise     (q_rise),
      .q_fall     (q_fall),
      .busy       (busy),
      .pend       (pend),
      .coll_err   (coll_err),
      .redund_err (redund_err)
   );
   // vector order: {q, q_rise, q_fall, busy, pend, coll_err, redund_err}
   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         logic [6:0] e, a;
         e = sb.pop_front();
         a = {q, q_rise, q_fall, busy, pend, coll_err, redund_err};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL outvec act=%b exp=%b t=%0t", a, e, $time);
         end
      end
   end
   task automatic step(input logic r, input logic f, input logic [6:0] e);
      @(negedge clk);
      rise_req = r;
      fall_req = f;
      sb.push_back(e);
   endtask
   task automatic chk(input string nm, input logic a, input logic e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%b exp=%b t=%0t", nm, a, e, $time);
      end
   endtask
   task automatic async_rst();
      @(negedge clk);
      rise_req = 1'b0;
      fall_req = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_q", q, 1'b0);
      chk("rst_pend", pend, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_qrise", q_rise, 1'b0);
      @(negedge clk);
      rst = 1'b1;
   endtask
`ifdef EDGE_LEVEL_GEN_TOGGLE_EN
   logic tgl_t = 1'b0;
   logic qt, qt_rise, qt_fall, bt, pt, ct, rt;
   edge_level_gen #(.MIN_HIGH(1), .MIN_LOW(1)) u_t (
      .clk        (clk),
      .rst        (rst),
      .rise_req   (1'b0),
      .fall_req   (1'b0),
      .tgl_req    (tgl_t),
      .q          (qt),
      .q_rise     (qt_rise),
      .q_fall     (qt_fall),
      .busy       (bt),
      .pend       (pt),
      .coll_err   (ct),
      .redund_err (rt)
   );
`endif
   initial begin
      #3;
      chk("reset_q", q, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_pend", pend, 1'b0);
      chk("reset_errs", coll_err | redund_err | q_rise | q_fall, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      step(0, 0, 7'b0000000);
      step(1, 0, 7'b1101000);
      step(0, 0, 7'b1001000);
      step(0, 0, 7'b1001000);
      step(0, 0, 7'b1000000);
      step(0, 0, 7'b1000000);
      step(1, 0, 7'b1000001);
      step(1, 1, 7'b1000010);
      step(0, 1, 7'b0011000);
      step(1, 0, 7'b0001100);
      step(0, 0, 7'b0001100);
      step(0, 0, 7'b0000100);
      step(0, 0, 7'b1101000);
      step(0, 1, 7'b1001100);
      step(0, 0, 7'b1001100);
      step(0, 0, 7'b1000100);
      step(0, 0, 7'b0011000);
      step(1, 0, 7'b0001100);
      step(0, 1, 7'b0001000);
      step(0, 0, 7'b0000000);
      step(0, 0, 7'b0000000);
      step(1, 0, 7'b1101000);
      step(0, 1, 7'b1001100);
      step(1, 0, 7'b1001000);
      step(0, 0, 7'b1000000);
      step(0, 0, 7'b1000000);
      step(0, 1, 7'b0011000);
      step(0, 1, 7'b0001001);
      step(1, 1, 7'b0001010);
      step(0, 0, 7'b0000000);
      step(1, 0, 7'b1101000);
      step(0, 1, 7'b1001100);
      async_rst();
      step(0, 0, 7'b0000000);
      step(1, 0, 7'b1101000);
      step(0, 0, 7'b1001000);
      step(0, 0, 7'b1001000);
      step(0, 0, 7'b1000000);
      step(0, 1, 7'b0011000);
      step(1, 0, 7'b0001100);
      async_rst();
      step(0, 0, 7'b0000000);
      step(1, 0, 7'b1101000);
      step(0, 0, 7'b1001000);
      repeat (3) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain act=%0d exp=0", sb.size());
      end
`ifdef EDGE_LEVEL_GEN_TOGGLE_EN
      begin
         logic lvl, prev, tg;
         lvl = 1'b0;
         @(posedge clk);
         #1 prev = qt;
         chk("tgl_init", qt, 1'b0);
         for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            tg = 1'($urandom_range(0, 1));
            tgl_t = tg;
            lvl = lvl ^ tg;
            @(posedge clk);
            #1;
            chk("tgl_level", qt, lvl);
            chk("tgl_rise", qt & ~prev, tg & lvl);
            chk("tgl_fall", ~qt & prev, tg & ~lvl);
            chk("tgl_qrise", qt_rise, qt & ~prev);
            chk("tgl_qfall", qt_fall, ~qt & prev);
            prev = qt;
         end
         tgl_t = 1'b0;
      end
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
